// File: rtl/updown_mod_counter_pkg.sv
// rtl/updown_mod_counter_pkg.sv - shared constants and step decode for the up/down modulo counter
//
// Purpose : limit-mode selectors and the step-command encoding used by
//           updown_mod_counter.
// Contents: CNT_WRAP / CNT_SAT mode values for the SAT parameter,
//           step_e command type, decode_step() helper.
package updown_mod_counter_pkg;

    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2
    } step_e;

    // inc and dec together cancel out: the counter holds and raises no carry/borrow.
    function automatic step_e decode_step(input logic inc, input logic dec);
        step_e s;
        s = STEP_NONE;
        if (inc && !dec) begin
            s = STEP_UP;
        end else if (dec && !inc) begin
            s = STEP_DOWN;
        end
        return s;
    endfunction

endpackage

// File: rtl/updown_mod_counter_if.sv
// rtl/updown_mod_counter_if.sv - command/status bundle for the up/down modulo counter
//
// Purpose : groups the counter's command inputs and status outputs.
// Signals : clr, ld, ld_val[WIDTH], inc, dec        (commands, driven by master)
//           count[WIDTH], co, bo, at_max, at_zero, ovf (status, driven by slave)
// Modports: master - controller side; slave - counter side.
interface updown_mod_counter_if #(
    parameter int WIDTH = 4
);

    logic             clr;
    logic             ld;
    logic [WIDTH-1:0] ld_val;
    logic             inc;
    logic             dec;
    logic [WIDTH-1:0] count;
    logic             co;
    logic             bo;
    logic             at_max;
    logic             at_zero;
    logic             ovf;

    modport master (
        output clr, ld, ld_val, inc, dec,
        input  count, co, bo, at_max, at_zero, ovf
    );

    modport slave (
        input  clr, ld, ld_val, inc, dec,
        output count, co, bo, at_max, at_zero, ovf
    );

endinterface

// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - up/down modulo-N counter with clear, load, wrap/saturate and cascade carry/borrow
//
// Purpose : loop-index / step counter, count range 0..MODULUS-1.
// Params  : WIDTH (>=2), MODULUS (2..2**WIDTH), SAT (CNT_WRAP or CNT_SAT).
// Ports   : clk       - rising-edge clock
//           rst       - synchronous reset, active-high
//           cnt       - updown_mod_counter_if.slave:
//                       clr/ld/ld_val/inc/dec commands in,
//                       count (registered), co/bo (combinational, chainable),
//                       at_max/at_zero (decoded from the register), ovf (sticky, registered)
module updown_mod_counter
    import updown_mod_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10,
    parameter int SAT     = CNT_WRAP
) (
    input  logic                  clk,
    input  logic                  rst,
    updown_mod_counter_if.slave   cnt
);

    generate
        if (WIDTH < 2 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_params
            $error("updown_mod_counter: MODULUS %0d out of range for WIDTH %0d", MODULUS, WIDTH);
        end
    endgenerate

    // Top count kept one bit wider so MODULUS = 2**WIDTH compares cleanly.
    localparam logic [WIDTH:0] MAX_W = (WIDTH + 1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAX_V = MAX_W[WIDTH-1:0];

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             hit_max;
    logic             hit_zero;
    logic             quiet;
    step_e            step;

    assign hit_max  = ({1'b0, count_q} == MAX_W);
    assign hit_zero = (count_q == '0);
    assign step     = decode_step(cnt.inc, cnt.dec);

    // Carry/borrow only when the step actually takes effect this edge, so
    // they can drive the next stage's inc/dec directly.
    assign quiet = ~rst & ~cnt.clr & ~cnt.ld;

    assign cnt.co      = quiet & (step == STEP_UP)   & hit_max;
    assign cnt.bo      = quiet & (step == STEP_DOWN) & hit_zero;
    assign cnt.at_max  = hit_max;
    assign cnt.at_zero = hit_zero;
    assign cnt.count   = count_q;
    assign cnt.ovf     = ovf_q;

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (cnt.clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (cnt.ld) begin
            // Out-of-range loads clamp so no count >= MODULUS is ever reachable.
            if ({1'b0, cnt.ld_val} > MAX_W) begin
                count_d = MAX_V;
            end else begin
                count_d = cnt.ld_val;
            end
        end else begin
            case (step)
                STEP_UP: begin
                    if (hit_max) begin
                        ovf_d = 1'b1;
                        if (SAT == CNT_WRAP) begin
                            count_d = '0;
                        end
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end
                STEP_DOWN: begin
                    if (hit_zero) begin
                        ovf_d = 1'b1;
                        if (SAT == CNT_WRAP) begin
                            count_d = MAX_V;
                        end
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb/tb_updown_mod_counter.sv - self-checking bench for updown_mod_counter
module tb_updown_mod_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Lanes: 0 = W4/M10 wrap, 1 = W4/M10 sat, 2 = units, 3 = tens (cascaded), 4 = W3/M8 sat
    logic       in_rst [5];
    logic       in_clr [5];
    logic       in_ld  [5];
    logic [3:0] in_ldv [5];
    logic       in_inc [5];
    logic       in_dec [5];

    logic [3:0] act_count [5];
    logic       act_co    [5];
    logic       act_bo    [5];
    logic       act_max   [5];
    logic       act_zero  [5];
    logic       act_ovf   [5];

    updown_mod_counter_if #(.WIDTH(4)) i0 ();
    updown_mod_counter_if #(.WIDTH(4)) i1 ();
    updown_mod_counter_if #(.WIDTH(4)) iu ();
    updown_mod_counter_if #(.WIDTH(4)) it ();
    updown_mod_counter_if #(.WIDTH(3)) i3 ();

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SAT(0)) d0 (.clk(clk), .rst(in_rst[0]), .cnt(i0));
    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SAT(1)) d1 (.clk(clk), .rst(in_rst[1]), .cnt(i1));
    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SAT(0)) du (.clk(clk), .rst(in_rst[2]), .cnt(iu));
    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SAT(0)) dt (.clk(clk), .rst(in_rst[2]), .cnt(it));
    updown_mod_counter #(.WIDTH(3), .MODULUS(8),  .SAT(1)) d3 (.clk(clk), .rst(in_rst[4]), .cnt(i3));

    assign i0.clr = in_clr[0]; assign i0.ld = in_ld[0]; assign i0.ld_val = in_ldv[0];
    assign i0.inc = in_inc[0]; assign i0.dec = in_dec[0];
    assign i1.clr = in_clr[1]; assign i1.ld = in_ld[1]; assign i1.ld_val = in_ldv[1];
    assign i1.inc = in_inc[1]; assign i1.dec = in_dec[1];
    assign iu.clr = in_clr[2]; assign iu.ld = in_ld[2]; assign iu.ld_val = in_ldv[2];
    assign iu.inc = in_inc[2]; assign iu.dec = in_dec[2];
    assign it.clr = in_clr[2]; assign it.ld = 1'b0;      assign it.ld_val = 4'd0;
    assign it.inc = iu.co;     assign it.dec = iu.bo;
    assign i3.clr = in_clr[4]; assign i3.ld = in_ld[4]; assign i3.ld_val = in_ldv[4][2:0];
    assign i3.inc = in_inc[4]; assign i3.dec = in_dec[4];

    assign act_count[0] = i0.count; assign act_co[0] = i0.co; assign act_bo[0] = i0.bo;
    assign act_max[0] = i0.at_max; assign act_zero[0] = i0.at_zero; assign act_ovf[0] = i0.ovf;
    assign act_count[1] = i1.count; assign act_co[1] = i1.co; assign act_bo[1] = i1.bo;
    assign act_max[1] = i1.at_max; assign act_zero[1] = i1.at_zero; assign act_ovf[1] = i1.ovf;
    assign act_count[2] = iu.count; assign act_co[2] = iu.co; assign act_bo[2] = iu.bo;
    assign act_max[2] = iu.at_max; assign act_zero[2] = iu.at_zero; assign act_ovf[2] = iu.ovf;
    assign act_count[3] = it.count; assign act_co[3] = it.co; assign act_bo[3] = it.bo;
    assign act_max[3] = it.at_max; assign act_zero[3] = it.at_zero; assign act_ovf[3] = it.ovf;
    assign act_count[4] = {1'b0, i3.count}; assign act_co[4] = i3.co; assign act_bo[4] = i3.bo;
    assign act_max[4] = i3.at_max; assign act_zero[4] = i3.at_zero; assign act_ovf[4] = i3.ovf;

    // Reference model: counter value as a plain integer plus a sticky flag.
    typedef struct {
        int cnt;
        bit ovf;
    } st_t;

    int  mod_a  [5] = '{10, 10, 10, 10, 8};
    int  sat_a  [5] = '{0, 1, 0, 0, 1};
    int  mask_a [5] = '{15, 15, 15, 15, 7};
    st_t st     [5];
    bit  samp_co [5];
    bit  samp_bo [5];

    int checks = 0;
    int errors = 0;

    function automatic void model(input int m, input int s, input st_t cur,
                                  input bit rr, input bit cc, input bit ll, input int lv,
                                  input bit ii, input bit dd,
                                  output st_t nx, output bit mco, output bit mbo);
        bit up;
        bit dn;
        bit quiet;
        up    = ii && !dd;
        dn    = dd && !ii;
        quiet = !rr && !cc && !ll;
        mco   = quiet && up && (cur.cnt == m - 1);
        mbo   = quiet && dn && (cur.cnt == 0);
        nx    = cur;
        if (rr || cc) begin
            nx.cnt = 0;
            nx.ovf = 1'b0;
        end else if (ll) begin
            nx.cnt = (lv >= m) ? m - 1 : lv;
        end else if (up) begin
            if (cur.cnt == m - 1) begin
                nx.ovf = 1'b1;
                nx.cnt = (s != 0) ? cur.cnt : 0;
            end else begin
                nx.cnt = cur.cnt + 1;
            end
        end else if (dn) begin
            if (cur.cnt == 0) begin
                nx.ovf = 1'b1;
                nx.cnt = (s != 0) ? 0 : m - 1;
            end else begin
                nx.cnt = cur.cnt - 1;
            end
        end
    endfunction

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane%0d: got %0d expected %0d (t=%0t)", nm, idx, act, exp, $time);
        end
    endtask

    // Called just after a negedge with inputs already applied; returns at the next negedge.
    task automatic cycle();
        st_t nx  [5];
        bit  mco [5];
        bit  mbo [5];
        bit  rr, cc, ll, ii, dd;
        int  lv;
        #1;
        for (int k = 0; k < 5; k++) begin
            if (k == 3) begin
                rr = in_rst[2]; cc = in_clr[2]; ll = 1'b0; lv = 0;
                ii = mco[2];    dd = mbo[2];
            end else begin
                rr = in_rst[k]; cc = in_clr[k]; ll = in_ld[k];
                lv = int'(in_ldv[k]) & mask_a[k];
                ii = in_inc[k]; dd = in_dec[k];
            end
            model(mod_a[k], sat_a[k], st[k], rr, cc, ll, lv, ii, dd, nx[k], mco[k], mbo[k]);
            samp_co[k] = act_co[k];
            samp_bo[k] = act_bo[k];
            chk("co", k, 8'(act_co[k]), 8'(mco[k]));
            chk("bo", k, 8'(act_bo[k]), 8'(mbo[k]));
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            st[k] = nx[k];
            chk("count",   k, 8'(act_count[k]), 8'(st[k].cnt));
            chk("ovf",     k, 8'(act_ovf[k]),   8'(st[k].ovf));
            chk("at_max",  k, 8'(act_max[k]),   8'(st[k].cnt == mod_a[k] - 1));
            chk("at_zero", k, 8'(act_zero[k]),  8'(st[k].cnt == 0));
        end
        @(negedge clk);
    endtask

    typedef struct {
        bit rst; bit clr; bit ld; int ldv; bit inc; bit dec;
        bit eco; bit ebo; int ecnt; bit eovf;
    } row_t;

    function automatic row_t row(input bit rst, input bit clr, input bit ld, input int ldv,
                                 input bit inc, input bit dec, input bit eco, input bit ebo,
                                 input int ecnt, input bit eovf);
        row_t r;
        r.rst = rst; r.clr = clr; r.ld = ld; r.ldv = ldv; r.inc = inc; r.dec = dec;
        r.eco = eco; r.ebo = ebo; r.ecnt = ecnt; r.eovf = eovf;
        return r;
    endfunction

    row_t tbl [$];

    task automatic idle_inputs(input int k);
        in_clr[k] = 1'b0; in_ld[k] = 1'b0; in_ldv[k] = 4'd0;
        in_inc[k] = 1'b0; in_dec[k] = 1'b0;
    endtask

    initial begin
        int exp_c3 [4] = '{6, 7, 7, 7};
        bit exp_co3 [4] = '{0, 0, 1, 1};
        bit exp_ov3 [4] = '{0, 0, 1, 1};

        for (int k = 0; k < 5; k++) begin
            in_rst[k] = 1'b1;
            idle_inputs(k);
            st[k].cnt = 0;
            st[k].ovf = 1'b0;
        end

        // Lane 0 (wrap, modulus 10) vector table
        tbl.push_back(row(1,0,0,0, 0,0, 0,0, 0,0));
        tbl.push_back(row(1,0,0,0, 1,0, 0,0, 0,0));
        for (int v = 1; v <= 9; v++) tbl.push_back(row(0,0,0,0, 1,0, 0,0, v,0));
        tbl.push_back(row(0,0,0,0,  1,0, 1,0, 0,1));
        tbl.push_back(row(0,1,0,0,  1,0, 0,0, 0,0));
        tbl.push_back(row(0,0,0,0,  0,1, 0,1, 9,1));
        tbl.push_back(row(0,1,0,0,  0,0, 0,0, 0,0));
        tbl.push_back(row(0,0,1,6,  1,0, 0,0, 6,0));
        tbl.push_back(row(0,0,1,13, 0,0, 0,0, 9,0));
        tbl.push_back(row(0,0,1,6,  0,0, 0,0, 6,0));
        tbl.push_back(row(0,0,0,0,  1,1, 0,0, 6,0));
        tbl.push_back(row(0,0,0,0,  0,1, 0,0, 5,0));
        tbl.push_back(row(0,0,1,9,  0,0, 0,0, 9,0));
        tbl.push_back(row(0,0,1,2,  1,0, 0,0, 2,0));
        tbl.push_back(row(0,0,0,0,  0,1, 0,0, 1,0));
        tbl.push_back(row(0,0,0,0,  0,1, 0,0, 0,0));
        tbl.push_back(row(0,0,0,0,  0,1, 0,1, 9,1));
        tbl.push_back(row(1,0,0,0,  1,0, 0,0, 0,0));

        @(negedge clk);
        foreach (tbl[i]) begin
            in_rst[0] = tbl[i].rst; in_clr[0] = tbl[i].clr; in_ld[0] = tbl[i].ld;
            in_ldv[0] = 4'(tbl[i].ldv); in_inc[0] = tbl[i].inc; in_dec[0] = tbl[i].dec;
            cycle();
            chk("tbl_co",    i, 8'(samp_co[0]),   8'(tbl[i].eco));
            chk("tbl_bo",    i, 8'(samp_bo[0]),   8'(tbl[i].ebo));
            chk("tbl_count", i, 8'(act_count[0]), 8'(tbl[i].ecnt));
            chk("tbl_ovf",   i, 8'(act_ovf[0]),   8'(tbl[i].eovf));
            chk("tbl_at_max", i, 8'(act_max[0]),  8'(tbl[i].ecnt == 9));
        end
        in_rst[0] = 1'b0;
        idle_inputs(0);

        // Lane 1 saturating: borrow at 0 holds, carry at 9 holds
        in_rst[1] = 1'b0;
        in_dec[1] = 1'b1;
        cycle();
        chk("sat_bo", 1, 8'(samp_bo[1]), 8'd1);
        chk("sat_hold0", 1, 8'(act_count[1]), 8'd0);
        chk("sat_ovf", 1, 8'(act_ovf[1]), 8'd1);
        in_dec[1] = 1'b0; in_ld[1] = 1'b1; in_ldv[1] = 4'd8;
        cycle();
        in_ld[1] = 1'b0; in_inc[1] = 1'b1;
        cycle();
        chk("sat_co_early", 1, 8'(samp_co[1]), 8'd0);
        chk("sat_cnt9", 1, 8'(act_count[1]), 8'd9);
        cycle();
        chk("sat_co", 1, 8'(samp_co[1]), 8'd1);
        chk("sat_hold9", 1, 8'(act_count[1]), 8'd9);
        idle_inputs(1);

        // Lane 4: WIDTH=3, MODULUS=8, saturating, from 5
        in_rst[4] = 1'b0; in_ld[4] = 1'b1; in_ldv[4] = 4'd5;
        cycle();
        chk("w3_load", 4, 8'(act_count[4]), 8'd5);
        in_ld[4] = 1'b0; in_inc[4] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            cycle();
            chk("w3_co",    j, 8'(samp_co[4]),   8'(exp_co3[j]));
            chk("w3_count", j, 8'(act_count[4]), 8'(exp_c3[j]));
            chk("w3_ovf",   j, 8'(act_ovf[4]),   8'(exp_ov3[j]));
        end
        idle_inputs(4);

        // Cascade: units.co -> tens.inc, 25 increments -> 25, then reset mid-run
        in_rst[2] = 1'b0; in_inc[2] = 1'b1;
        repeat (25) cycle();
        chk("casc_units", 2, 8'(act_count[2]), 8'd5);
        chk("casc_tens",  3, 8'(act_count[3]), 8'd2);
        repeat (2) cycle();
        in_rst[2] = 1'b1;
        cycle();
        chk("casc_rst_units", 2, 8'(act_count[2]), 8'd0);
        chk("casc_rst_tens",  3, 8'(act_count[3]), 8'd0);
        in_rst[2] = 1'b0;
        idle_inputs(2);

        // Randomized traffic on every lane, checked against the model each cycle
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 5; k++) begin
                if (k != 3) begin
                    in_rst[k] = ($urandom_range(0, 31) == 0);
                    in_clr[k] = ($urandom_range(0, 15) == 0);
                    in_ld[k]  = ($urandom_range(0, 9) == 0);
                    in_ldv[k] = 4'($urandom_range(0, 15));
                    in_inc[k] = 1'($urandom_range(0, 1));
                    in_dec[k] = 1'($urandom_range(0, 2) == 0);
                end
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
